// File: rtl/mux_n_1_stream.sv
// mux_n_1_stream: N:1 channel mux (fixed select or round-robin) feeding a
// one-entry valid/ready output register.
module mux_n_1_stream #(
  parameter int WIDTH = 8,
  parameter int N = 8,
  localparam int SELW = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*WIDTH-1:0]   in_data_i,
  input  logic [N-1:0]         in_valid_i,
  output logic [N-1:0]         in_ready_o,
  input  logic [SELW-1:0]      sel_i,
  input  logic                 sel_load_i,
  input  logic                 rr_en_i,
  output logic [WIDTH-1:0]     out_data_o,
  output logic [SELW-1:0]      out_chan_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic                 sel_err_o
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t          state_q;
  logic [WIDTH-1:0] data_q;
  logic [SELW-1:0]  chan_q, sel_q, last_q, gnt, idx;
  logic             err_q, gnt_ok, space, xfer;
  // Round-robin: scan downward so the closest channel after last_q wins last.
  always_comb begin
    gnt    = sel_q;
    gnt_ok = (int'(sel_q) < N) && in_valid_i[sel_q];
    idx    = '0;
    if (rr_en_i) begin
      gnt_ok = 1'b0;
      for (int i = N; i >= 1; i--) begin
        idx = SELW'((int'(last_q) + i) % N);
        if (in_valid_i[idx]) begin
          gnt_ok = 1'b1;
          gnt    = idx;
        end
      end
    end
  end
  assign space       = (state_q == EMPTY) || out_ready_i;
  assign xfer        = gnt_ok && space && rst_n;
  assign in_ready_o  = xfer ? N'(1) << gnt : '0;
  assign out_valid_o = (state_q == FULL);
  assign out_data_o  = data_q;
  assign out_chan_o  = chan_q;
  assign sel_err_o   = err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      chan_q  <= '0;
      sel_q   <= '0;
      last_q  <= SELW'(N - 1);
      err_q   <= 1'b0;
    end else begin
      if (sel_load_i) begin
        sel_q <= sel_i;
        if (int'(sel_i) >= N) err_q <= 1'b1;
      end
      if (xfer) begin
        state_q <= FULL;
        data_q  <= in_data_i[int'(gnt)*WIDTH +: WIDTH];
        chan_q  <= gnt;
        last_q  <= gnt;
      end else if (out_ready_i) begin
        state_q <= EMPTY;
      end
    end
  end
endmodule

// File: tb/tb_mux_n_1_stream.sv
// tb_mux_n_1_stream: table-driven checks of an N=8 instance plus hand sequences
// for an N=6 illegal-select case and asynchronous reset.
module tb_mux_n_1_stream;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [63:0] d8;
  logic [7:0]  v8, r8, od8;
  logic [2:0]  s8, oc8;
  logic        l8, rr8, or8, ov8, e8;
  logic [47:0] d6;
  logic [5:0]  v6, r6;
  logic [7:0]  od6;
  logic [2:0]  s6, oc6;
  logic        l6, rr6, or6, ov6, e6;

  mux_n_1_stream #(.WIDTH(8), .N(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_data_i(d8), .in_valid_i(v8), .in_ready_o(r8),
    .sel_i(s8), .sel_load_i(l8), .rr_en_i(rr8), .out_data_o(od8), .out_chan_o(oc8),
    .out_valid_o(ov8), .out_ready_i(or8), .sel_err_o(e8));

  mux_n_1_stream #(.WIDTH(8), .N(6)) u6 (
    .clk(clk), .rst_n(rst_n), .in_data_i(d6), .in_valid_i(v6), .in_ready_o(r6),
    .sel_i(s6), .sel_load_i(l6), .rr_en_i(rr6), .out_data_o(od6), .out_chan_o(oc6),
    .out_valid_o(ov6), .out_ready_i(or6), .sel_err_o(e6));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       ld;
    logic [2:0] sel;
    logic       rr;
    logic [7:0] v;
    logic       ordy;
    logic [7:0] d3;
    logic [7:0] erdy;
    logic       ev;
    logic [7:0] ed;
    logic [2:0] ech;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t r(logic ld, logic [2:0] sel, logic rr, logic [7:0] v, logic ordy,
                             logic [7:0] d3, logic [7:0] erdy, logic ev, logic [7:0] ed,
                             logic [2:0] ech);
    vec_t t;
    t.ld = ld; t.sel = sel; t.rr = rr; t.v = v; t.ordy = ordy; t.d3 = d3;
    t.erdy = erdy; t.ev = ev; t.ed = ed; t.ech = ech;
    return t;
  endfunction

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic apply8(input vec_t t);
    @(negedge clk);
    l8 = t.ld; s8 = t.sel; rr8 = t.rr; v8 = t.v; or8 = t.ordy;
    for (int k = 0; k < 8; k++) d8[k*8 +: 8] = (k == 3) ? t.d3 : 8'(8'hA0 + k);
    #1;
    chk("in_ready", 64'(r8), 64'(t.erdy));
    chk("in_ready_onehot0", 64'($onehot0(r8)), 64'd1);
    @(posedge clk);
    #1;
    chk("out_valid", 64'(ov8), 64'(t.ev));
    chk("out_data", 64'(od8), 64'(t.ed));
    chk("out_chan", 64'(oc8), 64'(t.ech));
    chk("sel_err8", 64'(e8), 64'd0);
  endtask

  task automatic step6(input logic ld, input logic [2:0] sel, input logic [5:0] v,
                       input logic [5:0] erdy, input logic ev, input logic [7:0] ed,
                       input logic [2:0] ech, input logic eerr);
    @(negedge clk);
    l6 = ld; s6 = sel; v6 = v;
    #1;
    chk("n6_in_ready", 64'(r6), 64'(erdy));
    @(posedge clk);
    #1;
    chk("n6_out_valid", 64'(ov6), 64'(ev));
    chk("n6_out_data", 64'(od6), 64'(ed));
    chk("n6_out_chan", 64'(oc6), 64'(ech));
    chk("n6_sel_err", 64'(e6), 64'(eerr));
  endtask

  initial begin
    rst_n = 1'b0;
    l8 = 0; s8 = 0; rr8 = 1; v8 = 8'hFF; or8 = 1;
    for (int k = 0; k < 8; k++) d8[k*8 +: 8] = 8'(8'hA0 + k);
    l6 = 0; s6 = 0; rr6 = 0; v6 = 6'h00; or6 = 1;
    for (int k = 0; k < 6; k++) d6[k*8 +: 8] = 8'(8'hB0 + k);

    // fixed mode: each load governs the grant one cycle later
    tv.push_back(r(1, 0, 0, 8'hFF, 1, 8'hA3, 8'h01, 1, 8'hA0, 0));
    tv.push_back(r(1, 1, 0, 8'hFF, 1, 8'hA3, 8'h01, 1, 8'hA0, 0));
    tv.push_back(r(1, 2, 0, 8'hFF, 1, 8'hA3, 8'h02, 1, 8'hA1, 1));
    tv.push_back(r(1, 3, 0, 8'hFF, 1, 8'hA3, 8'h04, 1, 8'hA2, 2));
    tv.push_back(r(1, 4, 0, 8'hFF, 1, 8'hA3, 8'h08, 1, 8'hA3, 3));
    tv.push_back(r(1, 5, 0, 8'hFF, 1, 8'hA3, 8'h10, 1, 8'hA4, 4));
    tv.push_back(r(1, 6, 0, 8'hFF, 1, 8'hA3, 8'h20, 1, 8'hA5, 5));
    tv.push_back(r(1, 7, 0, 8'hFF, 1, 8'hA3, 8'h40, 1, 8'hA6, 6));
    tv.push_back(r(0, 0, 0, 8'hFF, 1, 8'hA3, 8'h80, 1, 8'hA7, 7));
    // round-robin over ch1/4/6, then ch4 drops out
    tv.push_back(r(0, 0, 1, 8'h52, 1, 8'hA3, 8'h02, 1, 8'hA1, 1));
    tv.push_back(r(0, 0, 1, 8'h52, 1, 8'hA3, 8'h10, 1, 8'hA4, 4));
    tv.push_back(r(0, 0, 1, 8'h52, 1, 8'hA3, 8'h40, 1, 8'hA6, 6));
    tv.push_back(r(0, 0, 1, 8'h52, 1, 8'hA3, 8'h02, 1, 8'hA1, 1));
    tv.push_back(r(0, 0, 1, 8'h52, 1, 8'hA3, 8'h10, 1, 8'hA4, 4));
    tv.push_back(r(0, 0, 1, 8'h52, 1, 8'hA3, 8'h40, 1, 8'hA6, 6));
    tv.push_back(r(0, 0, 1, 8'h42, 1, 8'hA3, 8'h02, 1, 8'hA1, 1));
    tv.push_back(r(0, 0, 1, 8'h42, 1, 8'hA3, 8'h40, 1, 8'hA6, 6));
    tv.push_back(r(0, 0, 1, 8'h42, 1, 8'hA3, 8'h02, 1, 8'hA1, 1));
    // set last_q=6 through a fixed grant, then wrap 7 -> 0 -> 7
    tv.push_back(r(1, 6, 0, 8'h40, 1, 8'hA3, 8'h00, 0, 8'hA1, 1));
    tv.push_back(r(0, 0, 0, 8'h40, 1, 8'hA3, 8'h40, 1, 8'hA6, 6));
    tv.push_back(r(0, 0, 1, 8'h81, 1, 8'hA3, 8'h80, 1, 8'hA7, 7));
    tv.push_back(r(0, 0, 1, 8'h81, 1, 8'hA3, 8'h01, 1, 8'hA0, 0));
    tv.push_back(r(0, 0, 1, 8'h81, 1, 8'hA3, 8'h80, 1, 8'hA7, 7));
    // backpressure on ch3: held word must not follow the changing input
    tv.push_back(r(1, 3, 0, 8'h00, 1, 8'h5C, 8'h00, 0, 8'hA7, 7));
    tv.push_back(r(0, 0, 0, 8'h08, 0, 8'h5C, 8'h08, 1, 8'h5C, 3));
    tv.push_back(r(0, 0, 0, 8'h08, 0, 8'h77, 8'h00, 1, 8'h5C, 3));
    tv.push_back(r(0, 0, 0, 8'h08, 0, 8'h77, 8'h00, 1, 8'h5C, 3));
    tv.push_back(r(0, 0, 0, 8'h08, 0, 8'h77, 8'h00, 1, 8'h5C, 3));
    tv.push_back(r(0, 0, 0, 8'h08, 0, 8'h77, 8'h00, 1, 8'h5C, 3));
    tv.push_back(r(0, 0, 0, 8'h08, 1, 8'h77, 8'h08, 1, 8'h77, 3));
    tv.push_back(r(0, 0, 0, 8'h08, 1, 8'h78, 8'h08, 1, 8'h78, 3));
    tv.push_back(r(0, 0, 0, 8'h08, 1, 8'h79, 8'h08, 1, 8'h79, 3));

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(ov8), 64'd0);
    chk("rst_out_data", 64'(od8), 64'd0);
    chk("rst_out_chan", 64'(oc8), 64'd0);
    chk("rst_in_ready", 64'(r8), 64'd0);
    chk("rst_sel_err", 64'(e8), 64'd0);
    chk("rst_n6_out_valid", 64'(ov6), 64'd0);
    @(negedge clk);
    v8 = 8'h00;
    rr8 = 0;
    rst_n = 1'b1;

    foreach (tv[i]) apply8(tv[i]);

    // N=6: illegal select blocks fixed mode until a legal one is loaded
    step6(1, 7, 6'h00, 6'h00, 0, 8'h00, 0, 1);
    step6(0, 0, 6'h3F, 6'h00, 0, 8'h00, 0, 1);
    step6(0, 0, 6'h3F, 6'h00, 0, 8'h00, 0, 1);
    step6(1, 2, 6'h3F, 6'h00, 0, 8'h00, 0, 1);
    step6(0, 0, 6'h3F, 6'h04, 1, 8'hB2, 2, 1);
    step6(0, 0, 6'h00, 6'h00, 0, 8'hB2, 2, 1);

    // async reset while FULL and stalled
    @(negedge clk);
    or8 = 0; v8 = 8'h00;
    #1;
    chk("pre_rst_out_valid", 64'(ov8), 64'd1);
    chk("pre_rst_out_data", 64'(od8), 64'h79);
    #1 rst_n = 1'b0;
    #1;
    chk("async_out_valid", 64'(ov8), 64'd0);
    chk("async_out_data", 64'(od8), 64'd0);
    chk("async_out_chan", 64'(oc8), 64'd0);
    chk("async_in_ready", 64'(r8), 64'd0);
    chk("async_n6_sel_err", 64'(e6), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    apply8(r(0, 0, 1, 8'hFF, 1, 8'h79, 8'h01, 1, 8'hA0, 0));
    apply8(r(0, 0, 0, 8'hFF, 1, 8'h79, 8'h01, 1, 8'hA0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
